// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
//   muldiv_op_e    : operation code, identical to the RV32M funct3 field
//   muldiv_state_e : control FSM states of riscv_muldiv
//   DIV_STEPS      : quotient bits produced by the iterative divider
package riscv_pkg;

   localparam int unsigned DIV_STEPS = 32;

   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StMul  = 3'd1,
      StDiv  = 3'd2,
      StFix  = 3'd3,
      StDone = 3'd4
   } muldiv_state_e;

endpackage

// File: rtl/riscv_div_iter.sv
// Iterative unsigned restoring divider, one quotient bit per step.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   start_i        : load dividend/divisor and clear the step counter
//   step_i         : perform one iteration this cycle
//   dividend_i     : unsigned dividend (magnitude)
//   divisor_i      : unsigned divisor (magnitude)
//   done_o         : high during the cycle whose step produces the last bit
//   quotient_o     : quotient register
//   remainder_o    : partial / final remainder register
module riscv_div_iter #(
   parameter int unsigned W = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic         step_i,
   input  logic [W-1:0] dividend_i,
   input  logic [W-1:0] divisor_i,
   output logic         done_o,
   output logic [W-1:0] quotient_o,
   output logic [W-1:0] remainder_o
);
   import riscv_pkg::*;

   localparam int unsigned CntW = $clog2(DIV_STEPS);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [W-1:0]    quo_q, quo_d;
   logic [W-1:0]    rem_q, rem_d;
   logic [W-1:0]    dvs_q, dvs_d;
   logic [W:0]      shifted;
   logic [W-1:0]    diff;
   logic            fits;

   // The partial remainder stays below the divisor, so the difference fits in
   // W bits and modulo-W subtraction gives the exact restored value.
   assign shifted = {rem_q, quo_q[W-1]};
   assign fits    = (shifted >= {1'b0, dvs_q});
   assign diff    = shifted[W-1:0] - dvs_q;

   always_comb begin
      cnt_d = cnt_q;
      quo_d = quo_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      if (start_i) begin
         cnt_d = '0;
         quo_d = dividend_i;
         rem_d = '0;
         dvs_d = divisor_i;
      end else if (step_i) begin
         cnt_d = cnt_q + 1'b1;
         quo_d = {quo_q[W-2:0], fits};
         rem_d = fits ? diff : shifted[W-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
      end
   end

   assign done_o      = step_i & (cnt_q == CntW'(DIV_STEPS - 1));
   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;

endmodule

// File: rtl/riscv_muldiv.sv
// Multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : request, taken in IDLE or DONE
//   op_i          : RV32M funct3
//   rs1_i, rs2_i  : operands
//   rd_addr_i     : destination register
//   kill_i        : abort in-flight op, no write-back
//   busy_o        : unit occupied (MUL, DIV, FIX)
//   valid_o       : one-cycle write-back strobe
//   result_o      : write-back data, held until the next strobe
//   rd_addr_o     : write-back address, held with result_o
module riscv_muldiv #(
   parameter int unsigned XLEN         = 32,
   parameter bit          FAST_SPECIAL = 1'b1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            start_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic [4:0]      rd_addr_i,
   input  logic            kill_i,
   output logic            busy_o,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_addr_o
);
   import riscv_pkg::*;

   localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_e   state_q, state_d;
   logic [2:0]      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d;
   logic [4:0]      rd_q, rd_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [4:0]      rd_out_q, rd_out_d;

   logic            accept, in_signed, in_zero, in_ovf, in_special, div_start, div_done;
   logic [XLEN-1:0] in_mag_a, in_mag_b, quo, rem;

   assign accept     = start_i & ~kill_i & ((state_q == StIdle) | (state_q == StDone));
   assign in_signed  = ~op_i[0];
   assign in_zero    = (rs2_i == '0);
   assign in_ovf     = in_signed & (rs1_i == IntMin) & (rs2_i == '1);
   assign in_special = FAST_SPECIAL & op_i[2] & (in_zero | in_ovf);
   assign div_start  = accept & op_i[2] & ~in_special;
   assign in_mag_a   = (in_signed & rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
   assign in_mag_b   = (in_signed & rs2_i[XLEN-1]) ? -rs2_i : rs2_i;

   riscv_div_iter #(
      .W (XLEN)
   ) u_div (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .start_i     (div_start),
      .step_i      (state_q == StDiv),
      .dividend_i  (in_mag_a),
      .divisor_i   (in_mag_b),
      .done_o      (div_done),
      .quotient_o  (quo),
      .remainder_o (rem)
   );

   // 33x33 signed product; sign-extending to 2*XLEN keeps the low 2*XLEN bits exact.
   logic              mul_a_sgn, mul_b_sgn;
   logic [XLEN:0]     mul_a, mul_b;
   logic [2*XLEN-1:0] mul_prod;
   logic [XLEN-1:0]   mul_res;

   assign mul_a_sgn = (op_q != MULHU);
   assign mul_b_sgn = (op_q == MUL) | (op_q == MULH);
   assign mul_a     = {mul_a_sgn & a_q[XLEN-1], a_q};
   assign mul_b     = {mul_b_sgn & b_q[XLEN-1], b_q};
   assign mul_prod  = {{(XLEN-1){mul_a[XLEN]}}, mul_a} * {{(XLEN-1){mul_b[XLEN]}}, mul_b};
   assign mul_res   = (op_q == MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

   // Sign restore and RISC-V special cases. Specials are resolved here in both
   // modes; with FAST_SPECIAL they skip the divider and arrive straight in FIX.
   logic            s_a, s_b;
   logic [XLEN-1:0] q_fix, r_fix, div_res;

   always_comb begin
      s_a   = ~op_q[0] & a_q[XLEN-1];
      s_b   = ~op_q[0] & b_q[XLEN-1];
      q_fix = (s_a ^ s_b) ? -quo : quo;
      r_fix = s_a ? -rem : rem;
      if (b_q == '0) begin
         q_fix = '1;
         r_fix = a_q;
      end else if (~op_q[0] & (a_q == IntMin) & (b_q == '1)) begin
         q_fix = IntMin;
         r_fix = '0;
      end
      div_res = op_q[1] ? r_fix : q_fix;
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      rd_d     = rd_q;
      result_d = result_q;
      rd_out_d = rd_out_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               op_d = op_i;
               a_d  = rs1_i;
               b_d  = rs2_i;
               rd_d = rd_addr_i;
               if (!op_i[2])       state_d = StMul;
               else if (in_special) state_d = StFix;
               else                 state_d = StDiv;
            end else begin
               state_d = StIdle;
            end
         end
         StMul: begin
            state_d  = StDone;
            result_d = mul_res;
            rd_out_d = rd_q;
         end
         StDiv: begin
            if (div_done) state_d = StFix;
         end
         StFix: begin
            state_d  = StDone;
            result_d = div_res;
            rd_out_d = rd_q;
         end
         default: state_d = StIdle;
      endcase
      // Kill wins over everything, including a same-cycle start.
      if (kill_i) begin
         state_d  = StIdle;
         result_d = result_q;
         rd_out_d = rd_out_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         rd_q     <= '0;
         result_q <= '0;
         rd_out_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         rd_q     <= rd_d;
         result_q <= result_d;
         rd_out_q <= rd_out_d;
      end
   end

   assign busy_o    = (state_q == StMul) | (state_q == StDiv) | (state_q == StFix);
   assign valid_o   = (state_q == StDone) & ~kill_i;
   assign result_o  = result_q;
   assign rd_addr_o = rd_out_q;

endmodule

// File: tb/tb_riscv_muldiv.sv
`timescale 1ns/1ps
module tb_riscv_muldiv;

   localparam logic [31:0] IntMin = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs1, rs2;
   logic [4:0]  rd;
   logic        kill;
   logic        busy_f, valid_f, busy_s, valid_s;
   logic [31:0] result_f, result_s;
   logic [4:0]  rdo_f, rdo_s;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   riscv_muldiv #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut_fast (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
      .rd_addr_i(rd), .kill_i(kill), .busy_o(busy_f), .valid_o(valid_f), .result_o(result_f),
      .rd_addr_o(rdo_f)
   );

   riscv_muldiv #(.XLEN(32), .FAST_SPECIAL(1'b0)) dut_slow (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
      .rd_addr_i(rd), .kill_i(kill), .busy_o(busy_s), .valid_o(valid_s), .result_o(result_s),
      .rd_addr_o(rdo_s)
   );

   // Architectural RV32M result from plain 64-bit arithmetic.
   function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      logic [31:0] r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      p  = '0;
      r  = '0;
      case (o)
         3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
         3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
         3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
         3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
         3'd4: begin
            if (b == 32'd0) r = 32'hFFFF_FFFF;
            else if (a == IntMin && b == 32'hFFFF_FFFF) r = IntMin;
            else r = 32'(sa / sb);
         end
         3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) r = a;
            else if (a == IntMin && b == 32'hFFFF_FFFF) r = 32'd0;
            else r = 32'(sa % sb);
         end
         default: r = (b == 32'd0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Cycle of valid_o, counting the accept cycle as cycle 0.
   function automatic int ref_latency(input bit fast, input logic [2:0] o, input logic [31:0] a,
                                      input logic [31:0] b);
      if (!o[2]) return 2;
      if (fast && (b == 32'd0 || (!o[0] && a == IntMin && b == 32'hFFFF_FFFF))) return 2;
      return 34;
   endfunction

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r);
      @(negedge clk);
      start = 1'b1; op = o; rs1 = a; rs2 = b; rd = r;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Issue one op and watch both units for 40 cycles.
   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r, input logic [31:0] expv);
      int lat_f, lat_s, first_f, first_s, nv_f, nv_s, nb_f, nb_s;
      logic [31:0] res_f, res_s;
      logic [4:0]  ra_f, ra_s;
      lat_f = ref_latency(1'b1, o, a, b);
      lat_s = ref_latency(1'b0, o, a, b);
      first_f = 0; first_s = 0; nv_f = 0; nv_s = 0; nb_f = 0; nb_s = 0;
      res_f = 'x; res_s = 'x; ra_f = 'x; ra_s = 'x;
      issue(o, a, b, r);
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (busy_f) nb_f++;
         if (busy_s) nb_s++;
         if (valid_f) begin
            nv_f++;
            if (first_f == 0) begin first_f = cyc; res_f = result_f; ra_f = rdo_f; end
         end
         if (valid_s) begin
            nv_s++;
            if (first_s == 0) begin first_s = cyc; res_s = result_s; ra_s = rdo_s; end
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (res_f !== expv) begin
         n_fail++; $display("FAIL %s fast result: got %h want %h", name, res_f, expv);
      end
      n_checks++;
      if (res_s !== expv) begin
         n_fail++; $display("FAIL %s slow result: got %h want %h", name, res_s, expv);
      end
      n_checks++;
      if (first_f != lat_f || first_s != lat_s) begin
         n_fail++;
         $display("FAIL %s latency: got fast %0d slow %0d want fast %0d slow %0d",
                  name, first_f, first_s, lat_f, lat_s);
      end
      n_checks++;
      if (nv_f != 1 || nv_s != 1) begin
         n_fail++; $display("FAIL %s valid count: got %0d/%0d want 1/1", name, nv_f, nv_s);
      end
      n_checks++;
      if (nb_f != lat_f - 1 || nb_s != lat_s - 1) begin
         n_fail++;
         $display("FAIL %s busy cycles: got %0d/%0d want %0d/%0d", name, nb_f, nb_s,
                  lat_f - 1, lat_s - 1);
      end
      n_checks++;
      if (ra_f !== r || ra_s !== r) begin
         n_fail++; $display("FAIL %s rd: got %0d/%0d want %0d", name, ra_f, ra_s, r);
      end
      n_checks++;
      if (result_f !== expv || result_s !== expv || rdo_f !== r || rdo_s !== r) begin
         n_fail++;
         $display("FAIL %s hold: got %h/%h rd %0d/%0d want %h rd %0d", name, result_f,
                  result_s, rdo_f, rdo_s, expv, r);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0; kill = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({busy_f, valid_f, result_f, rdo_f, busy_s, valid_s, result_s, rdo_s} !== '0) begin
         n_fail++;
         $display("FAIL reset outputs: got %b %b %h %0d / %b %b %h %0d want all zero",
                  busy_f, valid_f, result_f, rdo_f, busy_s, valid_s, result_s, rdo_s);
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (busy_f !== 1'b0 || valid_f !== 1'b0 || busy_s !== 1'b0 || valid_s !== 1'b0) begin
         n_fail++; $display("FAIL idle after reset: got busy %b/%b valid %b/%b want 0",
                            busy_f, busy_s, valid_f, valid_s);
      end
   endtask

   task automatic test_mul();
      run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE);
      run_op("mul_ff",   3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0001);
      run_op("mulh_min", 3'd1, IntMin,        IntMin,        5'd3, 32'h4000_0000);
      run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF);
   endtask

   task automatic test_div();
      run_op("div_m7_2",  3'd4, -32'sd7, 32'd2, 5'd7, 32'hFFFF_FFFD);
      run_op("rem_m7_2",  3'd6, -32'sd7, 32'd2, 5'd8, 32'hFFFF_FFFF);
      run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd9, 32'd14);
      run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd10, 32'd2);
   endtask

   task automatic test_specials();
      run_op("divu_by0", 3'd5, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF);
      run_op("remu_by0", 3'd7, 32'd5, 32'd0, 5'd12, 32'd5);
      run_op("div_by0",  3'd4, -32'sd5, 32'd0, 5'd13, 32'hFFFF_FFFF);
      run_op("rem_by0",  3'd6, -32'sd5, 32'd0, 5'd14, 32'hFFFF_FFFB);
      run_op("div_ovf",  3'd4, IntMin, 32'hFFFF_FFFF, 5'd15, IntMin);
      run_op("rem_ovf",  3'd6, IntMin, 32'hFFFF_FFFF, 5'd16, 32'd0);
   endtask

   task automatic test_random();
      logic [2:0]  o;
      logic [31:0] a, b;
      for (int i = 0; i < 30; i++) begin
         o = 3'($urandom_range(0, 7));
         a = ($urandom_range(0, 7) == 0) ? IntMin : $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         run_op($sformatf("rand%0d_op%0d", i, o), o, a, b, 5'($urandom_range(0, 31)),
                ref_result(o, a, b));
      end
   endtask

   task automatic test_kill();
      bit seen;
      issue(3'd4, 32'd1000, 32'd7, 5'd3);
      repeat (10) begin @(posedge clk); #1; end
      @(negedge clk); kill = 1'b1; #1;
      n_checks++;
      if (valid_f !== 1'b0 || valid_s !== 1'b0) begin
         n_fail++; $display("FAIL kill_div valid: got %b/%b want 0", valid_f, valid_s);
      end
      @(posedge clk); #1; kill = 1'b0;
      n_checks++;
      if (busy_f !== 1'b0 || busy_s !== 1'b0) begin
         n_fail++; $display("FAIL kill_div idle: got busy %b/%b want 0", busy_f, busy_s);
      end
      seen = 1'b0;
      repeat (40) begin if (valid_f || valid_s) seen = 1'b1; @(posedge clk); #1; end
      n_checks++;
      if (seen) begin n_fail++; $display("FAIL kill_div writeback: got 1 want 0"); end
      run_op("kill_then_mul", 3'd0, 32'd3, 32'd4, 5'd9, 32'd12);
      // Kill in MUL: the previous write-back data must stay in place.
      issue(3'd0, 32'd5, 32'd6, 5'd10);
      @(negedge clk); kill = 1'b1;
      @(posedge clk); #1; kill = 1'b0;
      seen = 1'b0;
      repeat (5) begin if (valid_f || valid_s) seen = 1'b1; @(posedge clk); #1; end
      n_checks++;
      if (seen || result_f !== 32'd12 || result_s !== 32'd12 || rdo_f !== 5'd9 ||
          rdo_s !== 5'd9) begin
         n_fail++;
         $display("FAIL kill_mul: got valid %b result %h/%h rd %0d/%0d want 0 0000000c rd 9",
                  seen, result_f, result_s, rdo_f, rdo_s);
      end
      // Kill in DONE suppresses the strobe.
      issue(3'd0, 32'd7, 32'd8, 5'd11);
      @(posedge clk); #1;
      n_checks++;
      if (valid_f !== 1'b1 || valid_s !== 1'b1) begin
         n_fail++; $display("FAIL done_before_kill: got %b/%b want 1", valid_f, valid_s);
      end
      @(negedge clk); kill = 1'b1; #1;
      n_checks++;
      if (valid_f !== 1'b0 || valid_s !== 1'b0) begin
         n_fail++; $display("FAIL kill_done valid: got %b/%b want 0", valid_f, valid_s);
      end
      @(posedge clk); #1; kill = 1'b0;
      n_checks++;
      if (busy_f || valid_f || busy_s || valid_s) begin
         n_fail++; $display("FAIL kill_done idle: got busy %b/%b valid %b/%b want 0",
                            busy_f, busy_s, valid_f, valid_s);
      end
   endtask

   task automatic test_back_to_back();
      int first_f, first_s;
      @(negedge clk); start = 1'b1; op = 3'd0; rs1 = 32'd6; rs2 = 32'd7; rd = 5'd4;
      @(posedge clk); #1;
      // start stays high through MUL, where it is ignored
      @(negedge clk); op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd5;
      @(posedge clk); #1;
      n_checks++;
      if (valid_f !== 1'b1 || valid_s !== 1'b1 || result_f !== 32'd42 ||
          result_s !== 32'd42 || rdo_f !== 5'd4 || rdo_s !== 5'd4) begin
         n_fail++;
         $display("FAIL b2b first: got valid %b/%b result %h/%h rd %0d/%0d want 1 0000002a 4",
                  valid_f, valid_s, result_f, result_s, rdo_f, rdo_s);
      end
      @(posedge clk); #1; start = 1'b0;
      n_checks++;
      if (busy_f !== 1'b1 || busy_s !== 1'b1) begin
         n_fail++; $display("FAIL b2b second accepted: got busy %b/%b want 1", busy_f, busy_s);
      end
      first_f = 0; first_s = 0;
      for (int cyc = 3; cyc <= 45; cyc++) begin
         if (valid_f && first_f == 0) first_f = cyc;
         if (valid_s && first_s == 0) first_s = cyc;
         @(posedge clk); #1;
      end
      n_checks++;
      if (first_f != 36 || first_s != 36 || result_f !== 32'd14 || result_s !== 32'd14 ||
          rdo_f !== 5'd5 || rdo_s !== 5'd5) begin
         n_fail++;
         $display("FAIL b2b second: got cycle %0d/%0d result %h/%h rd %0d/%0d want 36 0000000e 5",
                  first_f, first_s, result_f, result_s, rdo_f, rdo_s);
      end
   endtask

   task automatic test_async_reset();
      bit seen;
      issue(3'd4, 32'd12345, 32'd11, 5'd20);
      repeat (4) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy_f, valid_f, result_f, rdo_f, busy_s, valid_s, result_s, rdo_s} !== '0) begin
         n_fail++;
         $display("FAIL async reset: got %b %b %h %0d / %b %b %h %0d want all zero",
                  busy_f, valid_f, result_f, rdo_f, busy_s, valid_s, result_s, rdo_s);
      end
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (valid_f || valid_s) seen = 1'b1; end
      n_checks++;
      if (seen) begin n_fail++; $display("FAIL async reset lost op: got valid want none"); end
      run_op("after_reset", 3'd7, 32'd12345, 32'd11, 5'd21, 32'd3);
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_specials();
      test_random();
      test_kill();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
